// File: rtl/eth_parser_pkg.sv
// Shared types for the ethernet parser slice.
// Metadata record layout and CSR statistics bundle.
package eth_parser_pkg;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic        vlan_present;
        logic [11:0] vlan_id;
        logic        is_ipv4;
        logic        is_ipv6;
        logic        is_arp;
        logic        is_unknown;
    } eth_metadata_t;

    localparam int META_W      = $bits(eth_metadata_t);
    localparam int STATS_CNT_W = 32;

    typedef struct packed {
        logic [STATS_CNT_W-1:0] ipv4;
        logic [STATS_CNT_W-1:0] ipv6;
        logic [STATS_CNT_W-1:0] arp;
        logic [STATS_CNT_W-1:0] unknown;
        logic [STATS_CNT_W-1:0] vlan;
        logic [STATS_CNT_W-1:0] drop;
    } meta_stats_t;

endpackage

// File: rtl/metadata_out_queue_meta_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear takes priority over a same-cycle increment.
module meta_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/metadata_out_queue.sv
// Captures packager metadata once per valid rise into a FWFT queue.
// Exposes a valid/ready stream and saturating per-protocol statistics.
module metadata_out_queue
    import eth_parser_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  eth_metadata_t            metadata_in,
    input  logic                     metadata_valid_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output eth_metadata_t            m_metadata,
    output logic [$clog2(DEPTH):0]   occupancy,
    input  logic                     stats_clear,
    output logic [CNT_W-1:0]         cnt_ipv4,
    output logic [CNT_W-1:0]         cnt_ipv6,
    output logic [CNT_W-1:0]         cnt_arp,
    output logic [CNT_W-1:0]         cnt_unknown,
    output logic [CNT_W-1:0]         cnt_vlan,
    output logic [CNT_W-1:0]         cnt_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    eth_metadata_t     mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic              valid_d_q;

    logic capture;
    logic pop;
    logic push;
    logic drop;

    // a full queue still accepts when the head leaves on the same edge
    assign capture = metadata_valid_in & ~valid_d_q;
    assign pop     = m_valid & m_ready;
    assign push    = capture & ((occ_q != FULL_OCC) | pop);
    assign drop    = capture & ~push;

    assign m_valid    = (occ_q != '0);
    assign m_metadata = mem_q[rd_ptr_q];
    assign occupancy  = occ_q;

    // previous level of the packager valid, for rise detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d_q <= 1'b0;
        end else begin
            valid_d_q <= metadata_valid_in;
        end
    end

    // storage write; the slot under rd_ptr is free again on a full push+pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= metadata_in;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // occupancy tracks push/pop imbalance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (push && !pop) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    meta_sat_counter #(.W(CNT_W)) u_cnt_ipv4 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clear),
        .inc   (push & metadata_in.is_ipv4),
        .count (cnt_ipv4)
    );

    meta_sat_counter #(.W(CNT_W)) u_cnt_ipv6 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clear),
        .inc   (push & metadata_in.is_ipv6),
        .count (cnt_ipv6)
    );

    meta_sat_counter #(.W(CNT_W)) u_cnt_arp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clear),
        .inc   (push & metadata_in.is_arp),
        .count (cnt_arp)
    );

    meta_sat_counter #(.W(CNT_W)) u_cnt_unknown (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clear),
        .inc   (push & metadata_in.is_unknown),
        .count (cnt_unknown)
    );

    meta_sat_counter #(.W(CNT_W)) u_cnt_vlan (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clear),
        .inc   (push & metadata_in.vlan_present),
        .count (cnt_vlan)
    );

    meta_sat_counter #(.W(CNT_W)) u_cnt_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clear),
        .inc   (drop),
        .count (cnt_drop)
    );

endmodule
